// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared widths and completion record for the ROB completion path
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef EXC_CAUSE_W
`define EXC_CAUSE_W 4
`endif

package rob_pkg;

  localparam int ROB_ENTRIES = 10;
  localparam int ROB_TAG_W   = $clog2(ROB_ENTRIES);
  localparam int CMPL_DATA_W = `WORD_SIZE;
  localparam int EXC_CAUSE_W = `EXC_CAUSE_W;

  typedef struct packed {
    logic [ROB_TAG_W-1:0]   tag;
    logic [CMPL_DATA_W-1:0] data;
`ifdef CMPL_EXC_EN
    logic                   exc;
    logic [EXC_CAUSE_W-1:0] cause;
`endif
  } cmpl_t;

endpackage

// File: rtl/rob_completion_arbiter_rr.sv
// rtl/rob_completion_arbiter_rr.sv - combinational round-robin picker starting at ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset down so the nearest request at or after ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rob_completion_arbiter.sv
// rtl/rob_completion_arbiter.sv - buffers FU completion reports and delivers one per cycle to the ROB
// Optional exception fields and exception-first priority are enabled by CMPL_EXC_EN.
module rob_completion_arbiter
  import rob_pkg::*;
#(
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int ROB_ENTRIES = 10,
  parameter int N_FU        = 4,
  localparam int TAG_W = $clog2(ROB_ENTRIES),
  localparam int SRC_W = $clog2(N_FU)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_FU-1:0]           fu_valid,
  output logic [N_FU-1:0]           fu_ready,
  input  logic [N_FU*TAG_W-1:0]     fu_tag,
  input  logic [N_FU*WORD_SIZE-1:0] fu_data,
`ifdef CMPL_EXC_EN
  input  logic [N_FU-1:0]             fu_exc,
  input  logic [N_FU*EXC_CAUSE_W-1:0] fu_cause,
  output logic                        cmpl_exc,
  output logic [EXC_CAUSE_W-1:0]      cmpl_cause,
`endif
  output logic                      cmpl_valid,
  input  logic                      cmpl_ready,
  output logic [TAG_W-1:0]          cmpl_tag,
  output logic [WORD_SIZE-1:0]      cmpl_data,
  output logic [SRC_W-1:0]          cmpl_src
);

  logic [N_FU-1:0]      buf_valid;
  logic [TAG_W-1:0]     buf_tag  [N_FU];
  logic [WORD_SIZE-1:0] buf_data [N_FU];
`ifdef CMPL_EXC_EN
  logic [N_FU-1:0]        buf_exc;
  logic [EXC_CAUSE_W-1:0] buf_cause [N_FU];
  logic [N_FU-1:0]        exc_req;
`endif

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] lock_idx;
  logic             locked;
  logic [N_FU-1:0]  arb_oh;
  logic [SRC_W-1:0] arb_idx;
  logic [N_FU-1:0]  sel_oh;
  logic [SRC_W-1:0] sel_idx;
  logic [N_FU-1:0]  grant_oh;
  logic [SRC_W-1:0] grant_idx;
  logic             handshake;

  rr_arbiter #(.N(N_FU)) u_rr (
    .req       (buf_valid),
    .ptr       (rr_ptr),
    .grant     (arb_oh),
    .grant_idx (arb_idx)
  );

  // A stalled grant stays locked so the ROB sees a stable report until it accepts.
  always_comb begin
    sel_oh  = arb_oh;
    sel_idx = arb_idx;
`ifdef CMPL_EXC_EN
    exc_req = buf_valid & buf_exc;
    for (int i = N_FU - 1; i >= 0; i--) begin
      if (exc_req[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_idx   = SRC_W'(i);
      end
    end
`endif
    grant_oh  = sel_oh;
    grant_idx = sel_idx;
    if (locked) begin
      grant_oh           = '0;
      grant_oh[lock_idx] = 1'b1;
      grant_idx          = lock_idx;
    end
  end

  assign cmpl_valid = |buf_valid;
  assign cmpl_tag   = buf_tag[grant_idx];
  assign cmpl_data  = buf_data[grant_idx];
  assign cmpl_src   = grant_idx;
`ifdef CMPL_EXC_EN
  assign cmpl_exc   = buf_exc[grant_idx];
  assign cmpl_cause = buf_cause[grant_idx];
`endif

  assign handshake = cmpl_valid && cmpl_ready;
  assign fu_ready  = {N_FU{!flush}} & (~buf_valid | (grant_oh & {N_FU{handshake}}));

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      locked    <= 1'b0;
      lock_idx  <= '0;
      for (int i = 0; i < N_FU; i++) begin
        buf_tag[i]  <= '0;
        buf_data[i] <= '0;
`ifdef CMPL_EXC_EN
        buf_exc[i]   <= 1'b0;
        buf_cause[i] <= '0;
`endif
      end
    end else begin
      // A handshake coinciding with flush still advances the pointer; it is not replayed.
      if (handshake)
        rr_ptr <= (grant_idx == SRC_W'(N_FU - 1)) ? '0 : grant_idx + 1'b1;
      locked   <= cmpl_valid && !cmpl_ready && !flush;
      lock_idx <= grant_idx;
      for (int i = 0; i < N_FU; i++) begin
        if (flush) begin
          buf_valid[i] <= 1'b0;
        end else if (fu_valid[i] && fu_ready[i]) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
          buf_data[i]  <= fu_data[i*WORD_SIZE +: WORD_SIZE];
`ifdef CMPL_EXC_EN
          buf_exc[i]   <= fu_exc[i];
          buf_cause[i] <= fu_cause[i*EXC_CAUSE_W +: EXC_CAUSE_W];
`endif
        end else if (grant_oh[i] && handshake) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_completion_arbiter.sv
// tb/tb_rob_completion_arbiter.sv - scoreboard bench for rob_completion_arbiter
module tb_rob_completion_arbiter;
  import rob_pkg::*;

  localparam int N  = 4;
  localparam int TW = ROB_TAG_W;
  localparam int DW = CMPL_DATA_W;

  typedef struct packed {
    cmpl_t      c;
    logic [1:0] src;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [N-1:0]  fu_valid;
  logic [N-1:0]  fu_ready;
  logic [N*TW-1:0] fu_tag;
  logic [N*DW-1:0] fu_data;
  logic          cmpl_valid;
  logic          cmpl_ready;
  logic [TW-1:0] cmpl_tag;
  logic [DW-1:0] cmpl_data;
  logic [1:0]    cmpl_src;
`ifdef CMPL_EXC_EN
  logic [N-1:0]             fu_exc;
  logic [N*EXC_CAUSE_W-1:0] fu_cause;
  logic                     cmpl_exc;
  logic [EXC_CAUSE_W-1:0]   cmpl_cause;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_exp;
  exp_t mon_act;

  rob_completion_arbiter #(
    .WORD_SIZE   (DW),
    .ROB_ENTRIES (ROB_ENTRIES),
    .N_FU        (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_ready   (fu_ready),
    .fu_tag     (fu_tag),
    .fu_data    (fu_data),
`ifdef CMPL_EXC_EN
    .fu_exc     (fu_exc),
    .fu_cause   (fu_cause),
    .cmpl_exc   (cmpl_exc),
    .cmpl_cause (cmpl_cause),
`endif
    .cmpl_valid (cmpl_valid),
    .cmpl_ready (cmpl_ready),
    .cmpl_tag   (cmpl_tag),
    .cmpl_data  (cmpl_data),
    .cmpl_src   (cmpl_src)
  );

  always #5 clk = ~clk;

  // Every accepted completion must match the oldest expected report.
  always @(negedge clk) begin
    if (!rst && cmpl_valid && cmpl_ready) begin
      mon_act       = '0;
      mon_act.c.tag = cmpl_tag;
      mon_act.c.data = cmpl_data;
      mon_act.src   = cmpl_src;
`ifdef CMPL_EXC_EN
      mon_act.c.exc   = cmpl_exc;
      mon_act.c.cause = cmpl_cause;
`endif
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got src %0d tag %0d data %0h, required no completion", cmpl_src, cmpl_tag, cmpl_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL sb_report: got src %0d tag %0d data %0h, required src %0d tag %0d data %0h",
                   mon_act.src, mon_act.c.tag, mon_act.c.data, mon_exp.src, mon_exp.c.tag, mon_exp.c.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    fu_tag[i*TW +: TW]  = t;
    fu_data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [1:0] s,
                      input logic x, input int cause);
    exp_t e;
    e        = '0;
    e.c.tag  = t;
    e.c.data = d;
    e.src    = s;
`ifdef CMPL_EXC_EN
    e.c.exc   = x;
    e.c.cause = EXC_CAUSE_W'(cause);
`else
    if (x || cause != 0) e.src = s;
`endif
    sb_q.push_back(e);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (sb_q.size() != 0 && n < max_cyc);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reports outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    flush      = 1'b0;
    fu_valid   = '0;
    cmpl_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    @(negedge clk);
    checks += 5;
    if (cmpl_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", cmpl_valid); end
    if (cmpl_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0d required 0", cmpl_tag); end
    if (cmpl_data !== '0) begin errors++; $display("FAIL reset_data: got %0h required 0", cmpl_data); end
    if (cmpl_src !== '0) begin errors++; $display("FAIL reset_src: got %0d required 0", cmpl_src); end
    if (fu_ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b required 1111", fu_ready); end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    cmpl_ready = 1'b1;
    set_fu(1, 4'd3, DW'('hAB));
    fu_valid = 4'b0010;
    push(4'd3, DW'('hAB), 2'd1, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (cmpl_valid !== 1'b0) begin errors++; $display("FAIL single_bypass: got %b required 0", cmpl_valid); end
    cyc();
    fu_valid = '0;
    @(negedge clk);
    checks++;
    if (cmpl_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got %b required 1", cmpl_valid); end
    cyc();
    @(negedge clk);
    checks++;
    if (cmpl_valid !== 1'b0) begin errors++; $display("FAIL single_once: got %b required 0", cmpl_valid); end
    drain(4);
  endtask

  task automatic test_all_fus();
    int seq[N];
    logic [N-1:0] acc;
    reset_dut();
    for (int k = 0; k < 16; k++)
      push(TW'(k % 4), DW'((k % 4) * 16 + k / 4), 2'(k % 4), 1'b0, 0);
    cmpl_ready = 1'b1;
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 18; c++) begin
      for (int i = 0; i < N; i++) begin
        fu_valid[i] = (seq[i] < 4);
        set_fu(i, TW'(i), DW'(i * 16 + seq[i]));
      end
      @(negedge clk);
      if (c >= 1 && c <= 16) begin
        checks++;
        if (cmpl_valid !== 1'b1 || fu_ready[(c - 1) % 4] !== 1'b1) begin
          errors++;
          $display("FAIL rr_stream c=%0d: got valid %b ready %b, required valid 1 ready[%0d] 1",
                   c, cmpl_valid, fu_ready, (c - 1) % 4);
        end
      end
      acc = fu_valid & fu_ready;
      cyc();
      for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
    end
    fu_valid = '0;
    drain(8);
  endtask

  task automatic test_backpressure();
    reset_dut();
    cmpl_ready = 1'b0;
    set_fu(0, 4'd5, DW'('h10));
    set_fu(2, 4'd6, DW'('h20));
    fu_valid = 4'b0101;
    push(4'd5, DW'('h10), 2'd0, 1'b0, 0);
    push(4'd6, DW'('h20), 2'd2, 1'b0, 0);
    cyc();
    fu_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (cmpl_src !== 2'd0 || cmpl_tag !== 4'd5 || fu_ready[0] !== 1'b0 || fu_ready[2] !== 1'b0) begin
        errors++;
        $display("FAIL stall c=%0d: got src %0d tag %0d ready %b, required src 0 tag 5 ready[0]=ready[2]=0",
                 c, cmpl_src, cmpl_tag, fu_ready);
      end
      cyc();
    end
    cmpl_ready = 1'b1;
    drain(4);
  endtask

  task automatic test_flush();
    cmpl_ready = 1'b0;
    set_fu(0, 4'd1, DW'('h1));
    set_fu(1, 4'd2, DW'('h2));
    set_fu(2, 4'd3, DW'('h3));
    fu_valid = 4'b0111;
    cyc();
    fu_valid = '0;
    @(negedge clk);
    checks++;
    if (cmpl_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b required 1", cmpl_valid); end
    cyc();
    flush = 1'b1;
    set_fu(3, 4'd8, DW'('hEE));
    fu_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (fu_ready !== 4'h0) begin errors++; $display("FAIL flush_ready: got %b required 0000", fu_ready); end
    cyc();
    flush    = 1'b0;
    fu_valid = '0;
    @(negedge clk);
    checks++;
    if (cmpl_valid !== 1'b0 || fu_ready !== 4'hF) begin
      errors++;
      $display("FAIL flush_post: got valid %b ready %b, required valid 0 ready 1111", cmpl_valid, fu_ready);
    end
    cyc();
    cmpl_ready = 1'b1;
    set_fu(2, 4'd7, DW'('h77));
    fu_valid = 4'b0100;
    push(4'd7, DW'('h77), 2'd2, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (cmpl_valid !== 1'b0) begin errors++; $display("FAIL flush_new_early: got %b required 0", cmpl_valid); end
    cyc();
    fu_valid = '0;
    @(negedge clk);
    checks++;
    if (cmpl_valid !== 1'b1 || cmpl_tag !== 4'd7) begin
      errors++;
      $display("FAIL flush_new: got valid %b tag %0d, required valid 1 tag 7", cmpl_valid, cmpl_tag);
    end
    drain(4);
  endtask

  task automatic test_reset_mid();
    cmpl_ready = 1'b0;
    set_fu(3, 4'd2, DW'('h33));
    fu_valid = 4'b1000;
    cyc();
    fu_valid = '0;
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if (cmpl_valid !== 1'b0 || fu_ready !== 4'hF) begin
      errors++;
      $display("FAIL rst_mid: got valid %b ready %b, required valid 0 ready 1111", cmpl_valid, fu_ready);
    end
    cyc();
    rst = 1'b0;
    set_fu(0, 4'd1, DW'('h11));
    set_fu(3, 4'd4, DW'('h44));
    fu_valid   = 4'b1001;
    cmpl_ready = 1'b1;
    push(4'd1, DW'('h11), 2'd0, 1'b0, 0);
    push(4'd4, DW'('h44), 2'd3, 1'b0, 0);
    cyc();
    fu_valid = '0;
    drain(6);
  endtask

`ifdef CMPL_EXC_EN
  task automatic test_exc();
    reset_dut();
    cmpl_ready = 1'b1;
    set_fu(1, 4'd1, DW'('h1));
    set_fu(3, 4'd3, DW'('h3));
    fu_exc = 4'b1000;
    fu_cause[3*EXC_CAUSE_W +: EXC_CAUSE_W] = EXC_CAUSE_W'(5);
    fu_valid = 4'b1010;
    push(4'd3, DW'('h3), 2'd3, 1'b1, 5);
    push(4'd1, DW'('h1), 2'd1, 1'b0, 0);
    cyc();
    fu_valid = '0;
    fu_exc   = '0;
    drain(4);
    cmpl_ready = 1'b0;
    set_fu(1, 4'd4, DW'('h4));
    fu_valid = 4'b0010;
    push(4'd4, DW'('h4), 2'd1, 1'b0, 0);
    cyc();
    set_fu(2, 4'd6, DW'('h6));
    fu_exc = 4'b0100;
    fu_cause[2*EXC_CAUSE_W +: EXC_CAUSE_W] = EXC_CAUSE_W'(9);
    fu_valid = 4'b0100;
    push(4'd6, DW'('h6), 2'd2, 1'b1, 9);
    cyc();
    fu_valid = '0;
    fu_exc   = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (cmpl_src !== 2'd1 || cmpl_exc !== 1'b0) begin
        errors++;
        $display("FAIL exc_lock c=%0d: got src %0d exc %b, required src 1 exc 0", c, cmpl_src, cmpl_exc);
      end
      cyc();
    end
    cmpl_ready = 1'b1;
    drain(4);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    fu_valid   = '0;
    fu_tag     = '0;
    fu_data    = '0;
    cmpl_ready = 1'b0;
`ifdef CMPL_EXC_EN
    fu_exc   = '0;
    fu_cause = '0;
`endif
    test_reset();
    test_single();
    test_all_fus();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef CMPL_EXC_EN
    test_exc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
